// File: rtl/fog_ctrl_pkg.sv
// Shared types, register map and reset defaults for the FOG loop sequencer.
package fog_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CLOSED = 2'd2,
        ST_RSVD   = 2'd3
    } state_e;

    localparam int NUM_REGS = 7;

    localparam logic [2:0] ADDR_FREQ_CNT     = 3'd0;
    localparam logic [2:0] ADDR_AMP_H        = 3'd1;
    localparam logic [2:0] ADDR_AMP_L        = 3'd2;
    localparam logic [2:0] ADDR_WAIT_CNT     = 3'd3;
    localparam logic [2:0] ADDR_GAINSEL_STEP = 3'd4;
    localparam logic [2:0] ADDR_GAINSEL_RAMP = 3'd5;
    localparam logic [2:0] ADDR_LOCK_TH      = 3'd6;
    localparam logic [2:0] ADDR_RSVD         = 3'd7;

    localparam logic [31:0] RST_FREQ_CNT     = 32'd100;
    localparam logic [31:0] RST_AMP_H        = 32'd8192;
    localparam logic [31:0] RST_AMP_L        = 32'hFFFF_E000;
    localparam logic [31:0] RST_WAIT_CNT     = 32'd10;
    localparam logic [31:0] RST_GAINSEL_STEP = 32'd5;
    localparam logic [31:0] RST_GAINSEL_RAMP = 32'd5;
    localparam logic [31:0] RST_LOCK_TH      = 32'd100;

    // Reset value of bank entry idx (same for shadow and active copies).
    function automatic logic [31:0] rst_value(input int idx);
        case (idx)
            0:       return RST_FREQ_CNT;
            1:       return RST_AMP_H;
            2:       return RST_AMP_L;
            3:       return RST_WAIT_CNT;
            4:       return RST_GAINSEL_STEP;
            5:       return RST_GAINSEL_RAMP;
            6:       return RST_LOCK_TH;
            default: return 32'd0;
        endcase
    endfunction

    // Unsigned subtraction clamped at zero.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        if (a > b) return a - b;
        else       return 32'd0;
    endfunction

    // Magnitude of a signed 32-bit value in 33 bits so -2^31 stays large.
    function automatic logic [32:0] abs33(input logic [31:0] v);
        logic [32:0] ext;
        ext = {v[31], v};
        if (ext[32]) return 33'd0 - ext;
        else         return ext;
    endfunction

endpackage

// File: rtl/fog_param_bank.sv
// Shadow/active parameter bank: CPU writes land in the shadow copy and are
// transferred to the active copy at the first period boundary after a commit.
module fog_param_bank
    import fog_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_commit,
    input  logic        i_pb,
    output logic [31:0] o_freq_cnt,
    output logic [31:0] o_amp_H,
    output logic [31:0] o_amp_L,
    output logic [31:0] o_wait_cnt,
    output logic [31:0] o_gainSel_step,
    output logic [31:0] o_gainSel_ramp,
    output logic [31:0] o_lock_th,
    output logic        o_pending,
    output logic        o_commit_done,
    output logic        o_freq_chg
);

    logic [31:0] r_shd     [NUM_REGS];
    logic [31:0] r_act     [NUM_REGS];
    logic [31:0] w_shd_nxt [NUM_REGS];
    logic        r_pending;
    logic        r_commit_done;
    logic        w_apply;

    // Shadow bank with this cycle's write merged in; address 7 matches no entry.
    always_comb begin
        w_shd_nxt = r_shd;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_wr_en && (i_wr_addr == 3'(k))) w_shd_nxt[k] = i_wr_data;
            else                                 w_shd_nxt[k] = r_shd[k];
        end
    end

    // Apply only uses the registered pending flag, so a commit arriving on a
    // boundary waits for the following boundary.
    assign w_apply    = i_pb & r_pending;
    assign o_freq_chg = w_apply & (w_shd_nxt[0] != r_act[0]);

    // Shadow/active storage, pending flag and apply pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_shd[k] <= rst_value(k);
                r_act[k] <= rst_value(k);
            end
            r_pending     <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_shd <= w_shd_nxt;
            if (w_apply) r_act <= w_shd_nxt;
            else         r_act <= r_act;
            r_pending     <= w_apply ? 1'b0 : (r_pending | i_commit);
            r_commit_done <= w_apply;
        end
    end

    assign o_freq_cnt     = r_act[0];
    assign o_amp_H        = r_act[1];
    assign o_amp_L        = r_act[2];
    assign o_wait_cnt     = r_act[3];
    assign o_gainSel_step = r_act[4];
    assign o_gainSel_ramp = r_act[5];
    assign o_lock_th      = r_act[6];
    assign o_pending      = r_pending;
    assign o_commit_done  = r_commit_done;

endmodule

// File: rtl/fog_loop_seq_ctrl.sv
// FOG loop sequencer: OPEN -> SETTLE -> CLOSED state machine with lock
// detection, driving the active parameter bank onto the datapath.
module fog_loop_seq_ctrl
    import fog_ctrl_pkg::*;
#(
    parameter int SETTLE_PERIODS = 64,
    parameter int LOCK_PERIODS   = 16,
    parameter int COARSE_SHIFT   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mod_trig,
    input  logic        i_status,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_commit,
    input  logic        i_loop_req,
    input  logic [31:0] i_err,
    output logic [31:0] o_freq_cnt,
    output logic [31:0] o_amp_H,
    output logic [31:0] o_amp_L,
    output logic [31:0] o_wait_cnt,
    output logic [31:0] o_gainSel_step,
    output logic [31:0] o_gainSel_ramp,
    output logic [31:0] o_fb_ON,
    output logic        o_pending,
    output logic        o_commit_done,
    output logic [1:0]  o_state,
    output logic        o_lock
);

    localparam int PW = $clog2(SETTLE_PERIODS + 1);
    localparam int LW = $clog2(LOCK_PERIODS + 1);

    state_e      r_state, w_state_nxt;
    logic [PW-1:0] r_per_cnt, w_per_nxt, w_per_inc;
    logic [LW-1:0] r_lock_cnt, w_lock_nxt;
    logic        r_fb_on;
    logic        r_lock;
    logic        w_pb;
    logic        w_freq_chg;
    logic [31:0] w_act_step;
    logic [31:0] w_lock_th;
    logic [32:0] w_err_mag;

    assign w_pb      = i_mod_trig & ~i_status;
    assign w_per_inc = r_per_cnt + PW'(1);
    assign w_err_mag = abs33(i_err);

    fog_param_bank u_bank (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_commit       (i_commit),
        .i_pb           (w_pb),
        .o_freq_cnt     (o_freq_cnt),
        .o_amp_H        (o_amp_H),
        .o_amp_L        (o_amp_L),
        .o_wait_cnt     (o_wait_cnt),
        .o_gainSel_step (w_act_step),
        .o_gainSel_ramp (o_gainSel_ramp),
        .o_lock_th      (w_lock_th),
        .o_pending      (o_pending),
        .o_commit_done  (o_commit_done),
        .o_freq_chg     (w_freq_chg)
    );

    // Next-state, settle-period counter and lock counter.
    always_comb begin
        w_state_nxt = r_state;
        w_per_nxt   = r_per_cnt;
        w_lock_nxt  = r_lock_cnt;
        case (r_state)
            ST_OPEN: begin
                w_per_nxt  = PW'(0);
                w_lock_nxt = LW'(0);
                if (w_pb && i_loop_req) w_state_nxt = ST_SETTLE;
                else                    w_state_nxt = ST_OPEN;
            end
            ST_SETTLE: begin
                w_lock_nxt = LW'(0);
                if (!i_loop_req) begin
                    w_state_nxt = ST_OPEN;
                    w_per_nxt   = PW'(0);
                end else if (w_pb) begin
                    if (w_per_inc == PW'(SETTLE_PERIODS)) begin
                        w_state_nxt = ST_CLOSED;
                        w_per_nxt   = PW'(0);
                    end else begin
                        w_per_nxt = w_per_inc;
                    end
                end else begin
                    w_per_nxt = r_per_cnt;
                end
            end
            ST_CLOSED: begin
                w_per_nxt = PW'(0);
                if (!i_loop_req) begin
                    w_state_nxt = ST_OPEN;
                    w_lock_nxt  = LW'(0);
                end else if (w_freq_chg) begin
                    // New modulation frequency invalidates the settled loop.
                    w_state_nxt = ST_SETTLE;
                    w_lock_nxt  = LW'(0);
                end else if (w_pb) begin
                    if (w_err_mag <= {1'b0, w_lock_th}) begin
                        if (r_lock_cnt == LW'(LOCK_PERIODS)) w_lock_nxt = r_lock_cnt;
                        else                                 w_lock_nxt = r_lock_cnt + LW'(1);
                    end else begin
                        w_lock_nxt = LW'(0);
                    end
                end else begin
                    w_lock_nxt = r_lock_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_OPEN;
                w_per_nxt   = PW'(0);
                w_lock_nxt  = LW'(0);
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_OPEN;
            r_per_cnt  <= PW'(0);
            r_lock_cnt <= LW'(0);
            r_fb_on    <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_per_cnt  <= w_per_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_fb_on    <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_CLOSED);
            r_lock     <= (w_lock_nxt == LW'(LOCK_PERIODS));
        end
    end

    // Coarse (reduced) gain while settling, full gain otherwise.
    always_comb begin
        if (r_state == ST_SETTLE) o_gainSel_step = sat_sub(w_act_step, 32'(COARSE_SHIFT));
        else                      o_gainSel_step = w_act_step;
    end

    assign o_fb_ON = {31'd0, r_fb_on};
    assign o_state = r_state;
    assign o_lock  = r_lock;

endmodule

// File: tb/tb_fog_loop_seq_ctrl.sv
// Self-checking bench for fog_loop_seq_ctrl: a per-cycle vector table for the
// commit/boundary protocol plus hand-written loop state sequences.
module tb_fog_loop_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_mod_trig = 1'b0;
    logic        i_status = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = 3'd0;
    logic [31:0] i_wr_data = 32'd0;
    logic        i_commit = 1'b0;
    logic        i_loop_req = 1'b0;
    logic [31:0] i_err = 32'd0;
    logic [31:0] o_freq_cnt, o_amp_H, o_amp_L, o_wait_cnt;
    logic [31:0] o_gainSel_step, o_gainSel_ramp, o_fb_ON;
    logic        o_pending, o_commit_done, o_lock;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_fail   = 0;

    fog_loop_seq_ctrl #(
        .SETTLE_PERIODS (4),
        .LOCK_PERIODS   (16),
        .COARSE_SHIFT   (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_mod_trig     (i_mod_trig),
        .i_status       (i_status),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_commit       (i_commit),
        .i_loop_req     (i_loop_req),
        .i_err          (i_err),
        .o_freq_cnt     (o_freq_cnt),
        .o_amp_H        (o_amp_H),
        .o_amp_L        (o_amp_L),
        .o_wait_cnt     (o_wait_cnt),
        .o_gainSel_step (o_gainSel_step),
        .o_gainSel_ramp (o_gainSel_ramp),
        .o_fb_ON        (o_fb_ON),
        .o_pending      (o_pending),
        .o_commit_done  (o_commit_done),
        .o_state        (o_state),
        .o_lock         (o_lock)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        wr_en;
        logic [2:0]  addr;
        logic [31:0] data;
        logic        commit;
        logic        trig;
        logic        status;
        logic [31:0] e_freq;
        logic [31:0] e_step;
        logic        e_cd;
        logic        e_pend;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input int we, input int ad, input int dt, input int cm,
                                input int tg, input int st, input int ef, input int es,
                                input int ec, input int ep);
        vec_t v;
        v.wr_en  = 1'(we);
        v.addr   = 3'(ad);
        v.data   = 32'(dt);
        v.commit = 1'(cm);
        v.trig   = 1'(tg);
        v.status = 1'(st);
        v.e_freq = 32'(ef);
        v.e_step = 32'(es);
        v.e_cd   = 1'(ec);
        v.e_pend = 1'(ep);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are settled #1 after the edge, pulse inputs then drop.
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_wr_en    = 1'b0;
        i_commit   = 1'b0;
        i_mod_trig = 1'b0;
        i_status   = 1'b0;
    endtask

    // Half-period edge with a bogus error (must be ignored), then a boundary.
    task automatic pb(input logic [31:0] err);
        i_mod_trig = 1'b1; i_status = 1'b1; i_err = 32'h7FFF_FFFF;
        tick();
        i_mod_trig = 1'b1; i_status = 1'b0; i_err = err;
        tick();
        i_err = 32'd0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        tick();
    endtask

    task automatic commit_apply();
        i_commit = 1'b1;
        tick();
        pb(32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_freq"},  o_freq_cnt,     32'd100);
        chk({tag, "_ampH"},  o_amp_H,        32'd8192);
        chk({tag, "_ampL"},  o_amp_L,        32'hFFFF_E000);
        chk({tag, "_wait"},  o_wait_cnt,     32'd10);
        chk({tag, "_step"},  o_gainSel_step, 32'd5);
        chk({tag, "_ramp"},  o_gainSel_ramp, 32'd5);
        chk({tag, "_fb"},    o_fb_ON,        32'd0);
        chk({tag, "_pend"},  {31'd0, o_pending},     32'd0);
        chk({tag, "_cd"},    {31'd0, o_commit_done}, 32'd0);
        chk({tag, "_state"}, {30'd0, o_state},       32'd0);
        chk({tag, "_lock"},  {31'd0, o_lock},        32'd0);
    endtask

    initial begin
        //            we ad  data cm tg st  freq step cd pend
        vecs[0]  = mk(0, 0,    0, 0, 0, 0,  100, 5, 0, 0);
        vecs[1]  = mk(1, 0,  200, 0, 0, 0,  100, 5, 0, 0);
        vecs[2]  = mk(0, 0,    0, 1, 0, 0,  100, 5, 0, 1);
        vecs[3]  = mk(0, 0,    0, 0, 1, 1,  100, 5, 0, 1);
        vecs[4]  = mk(0, 0,    0, 0, 0, 0,  100, 5, 0, 1);
        vecs[5]  = mk(0, 0,    0, 0, 1, 0,  200, 5, 1, 0);
        vecs[6]  = mk(0, 0,    0, 0, 0, 0,  200, 5, 0, 0);
        vecs[7]  = mk(0, 0,    0, 0, 1, 0,  200, 5, 0, 0);
        vecs[8]  = mk(0, 0,    0, 0, 1, 0,  200, 5, 0, 0);
        vecs[9]  = mk(0, 0,    0, 1, 0, 0,  200, 5, 0, 1);
        vecs[10] = mk(1, 4,    7, 0, 0, 0,  200, 5, 0, 1);
        vecs[11] = mk(0, 0,    0, 1, 0, 0,  200, 5, 0, 1);
        vecs[12] = mk(0, 0,    0, 0, 1, 0,  200, 7, 1, 0);
        vecs[13] = mk(0, 0,    0, 0, 0, 0,  200, 7, 0, 0);
        vecs[14] = mk(0, 0,    0, 0, 1, 0,  200, 7, 0, 0);
        vecs[15] = mk(1, 0,  300, 1, 1, 0,  200, 7, 0, 1);
        vecs[16] = mk(0, 0,    0, 0, 0, 0,  200, 7, 0, 1);
        vecs[17] = mk(0, 0,    0, 0, 1, 0,  300, 7, 1, 0);
        vecs[18] = mk(0, 0,    0, 1, 0, 0,  300, 7, 0, 1);
        vecs[19] = mk(1, 0,  400, 0, 1, 0,  400, 7, 1, 0);
        vecs[20] = mk(0, 0,    0, 0, 0, 0,  400, 7, 0, 0);
        vecs[21] = mk(1, 7,  999, 1, 0, 0,  400, 7, 0, 1);
        vecs[22] = mk(0, 0,    0, 0, 1, 0,  400, 7, 1, 0);

        // Reset state
        tick();
        tick();
        i_rst = 1'b0;
        chk_reset_outputs("rst");

        // Commit/boundary protocol table (loop stays open)
        for (int i = 0; i < NV; i++) begin
            i_wr_en    = vecs[i].wr_en;
            i_wr_addr  = vecs[i].addr;
            i_wr_data  = vecs[i].data;
            i_commit   = vecs[i].commit;
            i_mod_trig = vecs[i].trig;
            i_status   = vecs[i].status;
            tick();
            chk($sformatf("vec%0d_freq", i), o_freq_cnt,     vecs[i].e_freq);
            chk($sformatf("vec%0d_step", i), o_gainSel_step, vecs[i].e_step);
            chk($sformatf("vec%0d_cd", i),   {31'd0, o_commit_done}, {31'd0, vecs[i].e_cd});
            chk($sformatf("vec%0d_pend", i), {31'd0, o_pending},     {31'd0, vecs[i].e_pend});
            chk($sformatf("vec%0d_state", i), {30'd0, o_state}, 32'd0);
        end
        chk("addr7_ampH", o_amp_H, 32'd8192);
        chk("addr7_ampL", o_amp_L, 32'hFFFF_E000);
        chk("addr7_wait", o_wait_cnt, 32'd10);
        chk("addr7_ramp", o_gainSel_ramp, 32'd5);

        // Settle sequence with gainSel_step=1 (coarse value saturates to 0)
        wr(3'd4, 32'd1);
        commit_apply();
        chk("settle_pre_step", o_gainSel_step, 32'd1);
        i_loop_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pb(32'd0);
            chk($sformatf("settle_pb%0d_state", k), {30'd0, o_state}, 32'd1);
            chk($sformatf("settle_pb%0d_step", k),  o_gainSel_step,   32'd0);
            chk($sformatf("settle_pb%0d_fb", k),    o_fb_ON,          32'd1);
        end
        pb(32'd0);
        chk("settle_pb5_state", {30'd0, o_state}, 32'd2);
        chk("settle_pb5_step",  o_gainSel_step,   32'd1);
        chk("settle_pb5_fb",    o_fb_ON,          32'd1);

        // Lock detection: 16 in-threshold periods including both +/-100 edges
        pb(32'hFFFF_FF9C);
        chk("lock_pb1", {31'd0, o_lock}, 32'd0);
        for (int k = 2; k <= 15; k++) begin
            pb(32'd50);
            chk($sformatf("lock_pb%0d", k), {31'd0, o_lock}, 32'd0);
        end
        pb(32'd100);
        chk("lock_pb16", {31'd0, o_lock}, 32'd1);
        pb(32'hFFFF_FF9B);
        chk("lock_m101", {31'd0, o_lock}, 32'd0);
        for (int k = 1; k <= 15; k++) pb(32'd50);
        pb(32'h8000_0000);
        chk("lock_min_int", {31'd0, o_lock}, 32'd0);
        pb(32'd50);
        chk("lock_after_min_int", {31'd0, o_lock}, 32'd0);
        chk("lock_state_closed", {30'd0, o_state}, 32'd2);

        // Tighter lock_th via address 6; non-frequency apply keeps CLOSED
        wr(3'd6, 32'd10);
        commit_apply();
        chk("th_apply_state", {30'd0, o_state}, 32'd2);
        for (int k = 1; k <= 16; k++) begin
            pb((k == 1) ? 32'd50 : 32'hFFFF_FFF6);
            chk($sformatf("th_pb%0d", k), {31'd0, o_lock}, 32'd0);
        end
        pb(32'd10);
        chk("th_pb17", {31'd0, o_lock}, 32'd1);

        // Frequency commit in CLOSED returns to SETTLE at the apply cycle
        wr(3'd0, 32'd555);
        i_commit = 1'b1;
        tick();
        pb(32'd0);
        chk("fchg_freq",  o_freq_cnt, 32'd555);
        chk("fchg_cd",    {31'd0, o_commit_done}, 32'd1);
        chk("fchg_state", {30'd0, o_state},       32'd1);
        chk("fchg_lock",  {31'd0, o_lock},        32'd0);
        chk("fchg_fb",    o_fb_ON,                32'd1);
        pb(32'd0);
        pb(32'd0);
        chk("fchg_pb2_state", {30'd0, o_state}, 32'd1);
        i_loop_req = 1'b0;
        tick();
        chk("drop_state", {30'd0, o_state}, 32'd0);
        chk("drop_fb",    o_fb_ON,          32'd0);
        i_loop_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pb(32'd0);
            chk($sformatf("resettle_pb%0d", k), {30'd0, o_state}, 32'd1);
        end
        pb(32'd0);
        chk("resettle_pb5", {30'd0, o_state}, 32'd2);

        // Reset while a commit is pending
        i_loop_req = 1'b0;
        tick();
        wr(3'd0, 32'd777);
        i_commit = 1'b1;
        tick();
        chk("prerst_pend", {31'd0, o_pending}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_reset_outputs("midrst");
        pb(32'd0);
        chk("postrst_cd",   {31'd0, o_commit_done}, 32'd0);
        chk("postrst_freq", o_freq_cnt, 32'd100);
        commit_apply();
        chk("postrst_shadow_freq", o_freq_cnt, 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fog_loop_seq_ctrl.md
FOG_LOOP_SEQ_CTRL -- requirements
Module: fog_loop_seq_ctrl

Interface
REQ-001 Parameter SETTLE_PERIODS, default 64, number of full modulation periods spent in SETTLE.
REQ-002 Parameter LOCK_PERIODS, default 16, consecutive in-threshold periods required to assert lock.
REQ-003 Parameter COARSE_SHIFT, default 2, gain-select reduction applied during SETTLE.
REQ-004 i_clk  in  1  sole clock, CPU logic domain.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_mod_trig  in  1  one-cycle pulse at each modulation half-period edge.
REQ-007 i_status  in  1  modulation polarity, valid in the same cycle as i_mod_trig.
REQ-008 i_wr_en / i_wr_addr / i_wr_data  in  1/3/32  NIOS shadow-register write port.
REQ-009 i_commit  in  1  pulse requesting that the shadow bank be applied.
REQ-010 i_loop_req  in  1  level; 1 requests closed-loop operation.
REQ-011 i_err  in  32 signed  demodulated error, sampled only at period boundaries.
REQ-012 o_freq_cnt, o_amp_H, o_amp_L, o_wait_cnt, o_gainSel_step, o_gainSel_ramp  out  32 each  active datapath parameters.
REQ-013 o_fb_ON  out  32  feedback enable (0 or 1).
REQ-014 o_pending  out  1  a commit is waiting for a boundary.
REQ-015 o_commit_done  out  1  one-cycle pulse in the cycle the active bank updates.
REQ-016 o_state  out  2  encoded loop state; o_lock  out  1  loop locked.

Function
REQ-017 Address map: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 wait_cnt, 4 gainSel_step, 5 gainSel_ramp, 6 lock_th (unsigned); address 7 writes are ignored.
REQ-018 Shadow writes take effect in the cycle after i_wr_en and never alter the active outputs directly.
REQ-019 Period boundary (PB) is defined as i_mod_trig=1 with i_status=0 in the same cycle.
REQ-020 i_commit sets pending; an i_commit while pending is already set is coalesced.
REQ-021 At the first PB with pending set, the shadow bank (including any write in that same cycle) is copied to the active bank, visible one cycle later; o_commit_done pulses in that cycle and pending clears.
REQ-022 If i_commit and a PB occur in the same cycle, the apply takes place at the next PB, not the current one.
REQ-023 States: OPEN=0, SETTLE=1, CLOSED=2; encoding 3 is unreachable and recovers to OPEN.
REQ-024 OPEN: o_fb_ON=0; moves to SETTLE at a PB with i_loop_req=1.
REQ-025 SETTLE: o_fb_ON=1; o_gainSel_step = active gainSel_step - COARSE_SHIFT, saturating at 0; a period counter increments per PB; moves to CLOSED at the PB that brings the count to SETTLE_PERIODS.
REQ-026 CLOSED: o_fb_ON=1; o_gainSel_step = active value unmodified.
REQ-027 i_loop_req=0 in SETTLE or CLOSED forces OPEN on the next cycle without waiting for a PB; o_lock and all counters clear.
REQ-028 A commit apply that changes freq_cnt while in CLOSED returns the machine to SETTLE with the period counter zeroed; all other commit applies leave the state unchanged.
REQ-029 Lock counter in CLOSED: at each PB, if |i_err| <= lock_th the counter increments (saturating at LOCK_PERIODS), otherwise it clears; o_lock = (counter == LOCK_PERIODS).
REQ-030 |i_err| is computed in 33 bits so that -2^31 is treated as a large magnitude and never wraps to negative.
REQ-031 o_gainSel_ramp, o_freq_cnt, o_amp_*, and o_wait_cnt always equal their active-bank values.

Reset
REQ-032 Reset values for both banks: freq_cnt 100, amp_H 8192, amp_L 32'hFFFFE000, wait_cnt 10, gainSel_step 5, gainSel_ramp 5, lock_th 100.
REQ-033 Reset sets state OPEN, clears pending, clears all counters, and drives o_fb_ON=0, o_lock=0, o_commit_done=0, o_pending=0.
REQ-034 Reset asserted mid-pending discards the pending commit; the active bank returns to its reset values.

Structure
REQ-035 The state enum, the address constants, and the reset defaults reside in a shared package fog_ctrl_pkg.
REQ-036 The shadow/active register bank with the commit logic is a sub-module fog_param_bank; the state machine and lock logic remain in the top.

Verification
REQ-037 Write addr0=200, commit, then 3 PBs -> o_freq_cnt stays 100 until the first PB, becomes 200 one cycle later, and o_commit_done pulses exactly once.
REQ-038 Two commits before a PB, with a write addr4=7 between them -> a single apply at the PB with o_gainSel_step=7, and one o_commit_done pulse.
REQ-039 Raise i_loop_req, SETTLE_PERIODS=4, gainSel_step=1 -> o_gainSel_step=0 during SETTLE; at the 5th PB the state goes CLOSED and o_gainSel_step=1.
REQ-040 In CLOSED with lock_th=100, apply i_err=50 for 16 PBs, then -101 for 1 PB -> o_lock rises after the 16th PB and falls after the out-of-threshold PB; i_err=-2^31 never asserts lock.
REQ-041 In CLOSED, commit a new freq_cnt -> the state returns to SETTLE at the apply cycle; dropping i_loop_req mid-SETTLE -> OPEN with o_fb_ON=0 on the next cycle.
REQ-042 Assert i_rst while pending is set -> pending cleared, no apply at the next PB, and all outputs at their reset values.
